// File: rtl/drf_port_arbiter.sv
// rtl/drf_port_arbiter.sv - round-robin arbiter sharing the 4-bit port nibble channel
// Grants one requester per burst and feeds a one-deep registered valid/ready output stage.
module drf_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [4*NREQ-1:0] i_data_in,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic [3:0]        o_port_output,
  output logic              o_port_valid,
  input  logic              i_port_ready
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_g;
  logic [IW-1:0] r_ptr;
  logic [3:0]    r_cnt;
  logic [IW-1:0] w_sel;
  logic          w_any;
  logic          w_accept;
  logic          w_release;
  logic [3:0]    w_g_data;

  // Walk downward so the candidate closest after r_ptr is the one that sticks.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (i_req[idx]) begin
        w_any = 1'b1;
        w_sel = IW'(idx);
      end
    end
  end

  assign w_g_data  = i_data_in[4*int'(r_g) +: 4];
  assign w_accept  = (r_state == S_BUSY) && i_req[r_g] && (!o_port_valid || i_port_ready);
  assign w_release = (r_state == S_BUSY) &&
                     (!i_req[r_g] || (w_accept && (i_last[r_g] || r_cnt == 4'(MAX_BURST-1))));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ack = '0;
    if (w_accept) o_ack[r_g] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_g     <= '0;
      r_ptr   <= IW'(NREQ-1);
      r_cnt   <= 4'd0;
      o_grant <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_g     <= w_sel;
        r_ptr   <= w_sel;
        r_cnt   <= 4'd0;
        o_grant <= NREQ'(1) << w_sel;
      end else begin
        if (w_accept) r_cnt <= r_cnt + 4'd1;
        if (w_release) o_grant <= '0;
      end
    end
  end

  // The holding register drains on its own, so a nibble can outlive its grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_port_output <= 4'h0;
      o_port_valid  <= 1'b0;
    end else if (w_accept) begin
      o_port_output <= w_g_data;
      o_port_valid  <= 1'b1;
    end else if (o_port_valid && i_port_ready) begin
      o_port_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_drf_port_arbiter.sv
// tb/tb_drf_port_arbiter.sv - randomized and directed bench for drf_port_arbiter
// A transaction-level owner/queue model predicts grant, ack and port contents.
module tb_drf_port_arbiter;
  localparam int NREQ      = 3;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   last = '0;
  logic [4*NREQ-1:0] data_in = '0;
  logic              port_ready = 1'b1;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic [3:0]        port_output;
  logic              port_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack [NREQ];

  int       m_owner = -1;
  int       m_last  = NREQ-1;
  int       m_nburst = 0;
  logic [3:0] m_q = 4'h0;
  bit       m_full = 1'b0;

  drf_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_data_in     (data_in),
    .i_last        (last),
    .o_ack         (ack),
    .o_grant       (grant),
    .o_port_output (port_output),
    .o_port_valid  (port_valid),
    .i_port_ready  (port_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = NREQ-1;
    m_nburst = 0;
    m_full   = 1'b0;
    m_q      = 4'h0;
  endtask

  task automatic clear_acks();
    for (int i = 0; i < NREQ; i++) n_ack[i] = 0;
  endtask

  // One clock: ack judged mid-cycle, registered outputs judged just after the edge.
  task automatic step();
    logic [NREQ-1:0] exp_ack;
    bit acc;
    bit drain;
    @(negedge clk);
    exp_ack = '0;
    acc     = 1'b0;
    if (rst) model_reset();
    else if (m_owner >= 0 && req[m_owner] && (!m_full || port_ready)) begin
      acc = 1'b1;
      exp_ack[m_owner] = 1'b1;
    end
    check("ack", 32'(ack), 32'(exp_ack));
    for (int i = 0; i < NREQ; i++) if (ack[i]) n_ack[i]++;
    if (!rst) begin
      drain = m_full && port_ready;
      if (acc) begin
        m_q    = data_in[4*m_owner +: 4];
        m_full = 1'b1;
      end else if (drain) begin
        m_full = 1'b0;
      end
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (req[c]) begin
            m_owner  = c;
            m_last   = c;
            m_nburst = 0;
            break;
          end
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (acc) begin
        m_nburst++;
        if (last[m_owner] || m_nburst == MAX_BURST) m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("port_valid", 32'(port_valid), 32'(m_full));
    if (m_full) check("port_output", 32'(port_output), 32'(m_q));
  endtask

  initial begin
    clear_acks();
    // Reset with every requester asking.
    req = '1;
    data_in = 12'($urandom);
    repeat (2) step();
    check("rst_port_output", 32'(port_output), 32'h0);
    rst = 1'b0;
    clear_acks();
    for (int s = 1; s <= 15; s++) begin
      data_in = 12'($urandom);
      step();
      if (s == 1)  check("rot_grant0", 32'(grant), 32'b001);
      if (s == 6)  check("rot_grant1", 32'(grant), 32'b010);
      if (s == 11) check("rot_grant2", 32'(grant), 32'b100);
    end
    for (int i = 0; i < NREQ; i++) check("rot_burst_len", 32'(n_ack[i]), 32'd4);
    req = '0;
    repeat (2) step();

    // Requester 1 streams A,B,C with last on C.
    req = 3'b010;
    step();
    clear_acks();
    data_in = 12'h0A0; step(); check("stream_A", 32'(port_output), 32'hA);
    data_in = 12'h0B0; step(); check("stream_B", 32'(port_output), 32'hB);
    data_in = 12'h0C0; last = 3'b010; step();
    check("stream_C", 32'(port_output), 32'hC);
    check("stream_grant_off", 32'(grant), 32'd0);
    check("stream_acks", 32'(n_ack[1]), 32'd3);
    req = '0; last = '0;
    step();

    // Backpressure on requester 0 after nibble 5.
    req = 3'b001;
    step();
    data_in = 12'h005; step();
    check("bp_first", 32'(port_output), 32'h5);
    port_ready = 1'b0;
    data_in = 12'h006;
    clear_acks();
    repeat (5) begin
      step();
      check("bp_hold_out", 32'(port_output), 32'h5);
      check("bp_hold_grant", 32'(grant), 32'b001);
    end
    check("bp_no_ack", 32'(n_ack[0]), 32'd0);
    port_ready = 1'b1;
    step(); check("bp_resume6", 32'(port_output), 32'h6);
    data_in = 12'h007; step(); check("bp_resume7", 32'(port_output), 32'h7);
    data_in = 12'h008; step(); check("bp_resume8", 32'(port_output), 32'h8);
    check("bp_burst_end", 32'(grant), 32'd0);
    req = '0;
    step();

    // Grantee 0 drops out after two nibbles while 2 waits.
    req = 3'b001;
    step();
    req = 3'b101;
    repeat (2) begin data_in = 12'($urandom); step(); end
    req = 3'b100;
    step(); check("drop_idle", 32'(grant), 32'd0);
    step(); check("drop_next", 32'(grant), 32'b100);
    req = '0;
    repeat (2) step();

    // Asynchronous reset in the middle of requester 1's burst.
    req = 3'b010;
    step();
    data_in = 12'($urandom);
    step();
    port_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_valid", 32'(port_valid), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    req = '1;
    repeat (2) step();
    rst = 1'b0;
    port_ready = 1'b1;
    step();
    check("mid_rst_restart", 32'(grant), 32'b001);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) req[i] = ($urandom_range(0, 7) != 0);
        else        req[i] = ($urandom_range(0, 3) == 0);
        last[i] = ($urandom_range(0, 3) == 0);
      end
      data_in    = 12'($urandom);
      port_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drf_port_arbiter.md
# drf_port_arbiter

Round-robin arbiter that shares the 4-bit `port_output` nibble channel of `drf_system` between several requesters: the CPU core plus auxiliary sources such as a debug monitor or a program loader. It grants one requester at a time and moves nibbles into a one-deep registered output stage with a valid/ready handshake toward the port. The grant is held for a burst that ends on `last`, after `MAX_BURST` nibbles, or when the grantee drops `req`.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `MAX_BURST`, 4: maximum nibbles per grant (1..15).
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input NREQ: per-requester request; level, held while the requester has data.
- `data_in` input 4*NREQ: nibble of requester i at bits [4i+3:4i].
- `last` input NREQ: marks the current nibble of requester i as the final one of its burst.
- `ack` output NREQ: combinational; one-hot pulse, nibble of requester i accepted this cycle.
- `grant` output NREQ: registered; one-hot current owner, all-zero when idle.
- `port_output` output 4: registered nibble toward the port.
- `port_valid` output 1: registered; `port_output` holds a valid nibble.
- `port_ready` input 1: port consumes the nibble when `port_valid && port_ready`.

## Operation
- **States:** IDLE and BUSY, held in a 1-bit register. Additional registers:
  - grant index `g`;
  - priority pointer `ptr` (last granted index);
  - burst counter `cnt` (4 bits);
  - output holding register (`port_output`, `port_valid`).
- **IDLE:**
  - `grant` is all-zero.
  - If any `req` bit is set, select the first set bit searching `ptr+1, ptr+2, …`, wrapping modulo NREQ.
  - Next cycle: BUSY, `grant` one-hot at that index, `g` and `ptr` take that index, `cnt`=0.
- **Accept condition:** `accept = BUSY && req[g] && (!port_valid || port_ready)`.
  - `ack[g]` = `accept`; all other `ack` bits are 0.
  - On accept: `port_output` <= `data_in[g]`, `port_valid` <= 1, `cnt` <= `cnt`+1.
  - Otherwise, if `port_valid && port_ready`, then `port_valid` <= 0.
- **Release from BUSY to IDLE (next cycle, `grant` cleared):**
  - `accept && (last[g] || cnt == MAX_BURST-1)`, or
  - `req[g] == 0`: no accept occurs and release is immediate.
- **Output drain:** the holding register drains independently of state. A nibble still pending at release is kept until `port_ready`.
- **Fairness:** after a release, the released requester has lowest priority at the next arbitration.
- **Unused inputs:** `data_in` and `last` of non-granted requesters are ignored.

## Timing
- **Reset values:**
  - state IDLE;
  - `grant`=0, `ack`=0;
  - `port_output`=4'h0, `port_valid`=0;
  - `cnt`=0;
  - `ptr`=NREQ-1, so requester 0 has highest priority after reset.
- **Reset mid-burst:** the pending nibble is discarded and no `ack` is issued during reset.
- **Latency:**
  - `req` rise to `grant`: 1 cycle.
  - First `ack`: the same cycle `grant` is visible, if the output stage is free.
  - `ack` to `port_valid`: 1 cycle.
- **Throughput:** with `port_ready` held high, one nibble per cycle (accept and drain in the same cycle). A release costs exactly one idle arbitration cycle before the next grant.
- **Backpressure:** with `port_valid=1` and `port_ready=0`, no accept occurs. `port_output` and `port_valid` stay stable. `grant` is held.
- **Burst limit:** `cnt` counts accepted nibbles only, so at most MAX_BURST acks are issued per grant.
- **Single requester:** a lone requester still re-arbitrates after each burst and is granted again, one bubble cycle between bursts.
- **Simultaneous release and new requests:** arbitration uses the updated `ptr` on the next IDLE cycle.

## Test plan
- **Reset:** `rst` pulse, all `req` high. Required:
  - all outputs at reset values;
  - first grant after release is `grant`=3'b001;
  - then 3'b010 and 3'b100 in rotation, each burst 4 nibbles (MAX_BURST=4).
- **Stream with `last`:** requester 1 alone, `port_ready`=1, data 4'hA,4'hB,4'hC with `last` on 4'hC. Required:
  - `ack[1]` for 3 consecutive cycles;
  - `port_output` A,B,C on consecutive cycles, one cycle after each ack;
  - `grant` cleared after C.
- **Backpressure:** `port_ready`=0 for 5 cycles after the first nibble 4'h5. Required:
  - `port_output`=5 and `port_valid`=1 held;
  - no further `ack`;
  - transfer resumes one nibble per cycle when `port_ready`=1.
- **Requester drops out:** grantee 0 drops `req` mid-burst after 2 nibbles. Required:
  - next cycle `grant`=0;
  - following cycle `grant` goes to the next pending requester (2 if only 2 requests).
- **Reset mid-burst:** `rst` asserted while `port_valid`=1 and `grant`=3'b010. Required:
  - `port_valid`, `grant` and `ack` go to 0 immediately (asynchronous);
  - after release, arbitration restarts at requester 0.
